ddr2_traffic_gen: RTL and testbench
===================================

// Module: ddr2_traffic_gen
// PURPOSE
//  Synthesizable, parametrised stimulus/check engine for ddr2_controller; successor to file-driven pattern injection.
//  After controller READY and a start pulse, issues NUM_TXN scalar writes, then reads the same addresses back.
//  Checks every VALIDOUT word against an address-derived expected value; reports done/pass/error counts.
//  Sits between controller host port (CMD/SZ/OP/DIN/ADDR/FETCHING/FILLCOUNT/NOTFULL) and status logic.
// PARAMETERS
//  DATA_W      16          data width (DIN/DOUT)
//  ADDR_W      25          address width (ADDR/RADDR)
//  NUM_TXN     64          writes per run (= reads per run), 1..4096
//  ADDR_MODE   0           0 = sequential BASE_ADDR+i*STRIDE; 1 = 25-bit LFSR addresses
//  BASE_ADDR   0           start address, sequential mode
//  STRIDE      8           address increment, sequential mode
//  LFSR_SEED   25'h1ACE1   LFSR seed; 0 is replaced by 1
//  DATA_XOR    16'hA5C3    write data = addr[DATA_W-1:0] ^ DATA_XOR
//  FILL_LIMIT  56          no issue while fillcount >= FILL_LIMIT
//  TIMEOUT_CYC 4096        idle cycles after last read before abort
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high
//  start       in   1       one-cycle run request
//  ready       in   1       controller initialisation complete
//  fillcount   in   7       controller input-FIFO occupancy
//  notfull     in   1       controller can accept a command
//  dout        in   DATA_W  read data
//  raddr       in   ADDR_W  address of dout
//  validout    in   1       dout/raddr valid
//  cmd         out  3       0 NOP, 1 SCR (scalar read), 2 SCW (scalar write)
//  sz          out  2       always 0 (scalar)
//  op          out  3       always 0
//  fetching    out  1       cmd/addr/din valid this cycle
//  din         out  DATA_W  write data
//  addr        out  ADDR_W  command address
//  busy        out  1       run in progress
//  done        out  1       run finished; held until next start or reset
//  pass        out  1       valid with done: err_count==0 and rsp_count==NUM_TXN
//  err_count   out  16      mismatches + unexpected responses, saturating
//  rsp_count   out  16      read responses received, saturating
// BEHAVIOUR
//  Reset: all outputs 0 (cmd=NOP), FSM->IDLE, counters/LFSR cleared; reset mid-run aborts without done.
//  FSM: IDLE -(start)-> WAIT_RDY -(ready)-> WR -(NUM_TXN issued)-> RD -(NUM_TXN issued)-> WAIT_RSP -> DONE.
//  WAIT_RSP->DONE when rsp_count==NUM_TXN or TIMEOUT_CYC cycles with no validout (pass=0).
//  DONE -(start)-> WAIT_RDY; clears counters, reloads address generator. start ignored when busy.
//  Issue rule: fetching=1 for exactly one cycle per command, only if notfull==1 and fillcount<FILL_LIMIT;
//   otherwise fetching=0, cmd=NOP, addr/din hold. Back-to-back issue allowed every cycle.
//  Address gen: sequential wraps mod 2^ADDR_W; LFSR x^25+x^22+1 Galois, advanced once per issued cmd,
//   reloaded from seed at start of RD so read addresses equal write addresses in same order.
//  din = addr[DATA_W-1:0]^DATA_XOR on SCW; din=0 on SCR.
//  Check: on validout, expected = raddr[DATA_W-1:0]^DATA_XOR; order-independent (keyed by raddr).
//   mismatch -> err_count+1; validout outside RD/WAIT_RSP -> err_count+1, not counted in rsp_count.
//   rsp_count increments for each validout in RD/WAIT_RSP; both counters saturate at 16'hFFFF.
//  busy=1 in WAIT_RDY/WR/RD/WAIT_RSP; done/pass registered, asserted first cycle in DONE.
//  Response latency unbounded; timeout counter restarts on every validout.
// TESTING
//  1 ready=1, notfull=1, fillcount=0, NUM_TXN=4, seq BASE=0 STRIDE=8 -> SCW to 0,8,16,24 din 0xA5C3,0xA5CB,0xA5D3,0xA5DB; then SCR same addrs; 4 good responses -> done=1, pass=1.
//  2 notfull=0 for 10 cycles mid-WR -> fetching=0 those cycles, no command lost, 4 writes total.
//  3 fillcount=56 -> no issue; drop to 55 -> issue resumes next cycle.
//  4 one response dout corrupted (bit0 flipped) -> err_count=1, pass=0, rsp_count=4.
//  5 only 3 responses returned -> done after 4096 idle cycles, pass=0, rsp_count=3.
//  6 reset asserted during RD -> next cycle all outputs 0, FSM IDLE; new start runs cleanly; ADDR_MODE=1 reads repeat write address sequence.

Source files
------------

// File: rtl/ddr2_traffic_gen.sv
// ddr2_traffic_gen: write-then-read-back traffic engine for the ddr2_controller
// host port. After a start request and controller ready, it issues NUM_TXN
// scalar writes and then reads the same addresses back in the same order.
// Every returned word is checked against its address-derived value. The engine
// reports done, pass, an error count and a response count.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_RDY  | run requested, waiting for controller ready
// WR        | issuing scalar writes when the controller can accept them
// RD        | issuing scalar reads over the same address sequence
// WAIT_RSP  | all reads issued, collecting responses or timing out
// DONE      | result latched on done/pass, waiting for a new start
module ddr2_traffic_gen #(
    parameter int                 DATA_W      = 16,
    parameter int                 ADDR_W      = 25,
    parameter int                 NUM_TXN     = 64,
    parameter int                 ADDR_MODE   = 0,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int                 STRIDE      = 8,
    parameter logic [24:0]        LFSR_SEED   = 25'h1ACE1,
    parameter logic [DATA_W-1:0]  DATA_XOR    = 16'hA5C3,
    parameter int                 FILL_LIMIT  = 56,
    parameter int                 TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [6:0]        fillcount_i,
    input  logic              notfull_i,
    input  logic [DATA_W-1:0] dout_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              validout_i,
    output logic [2:0]        cmd_o,
    output logic [1:0]        sz_o,
    output logic [2:0]        op_o,
    output logic              fetching_o,
    output logic [DATA_W-1:0] din_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_count_o,
    output logic [15:0]       rsp_count_o
);

    localparam int CNT_W = $clog2(NUM_TXN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_SCR = 3'd1;
    localparam logic [2:0] CMD_SCW = 3'd2;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [24:0] SEED_EFF  = (LFSR_SEED == 25'd0) ? 25'd1 : LFSR_SEED;
    // Right-shifting Galois form of x^25 + x^22 + 1.
    localparam logic [24:0] LFSR_TAPS = 25'h1200000;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_TXN);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);
    localparam logic [15:0]      RSP_GOAL = 16'(NUM_TXN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_WR,
        S_RD,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  remain_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [ADDR_W-1:0] seq_q;
    logic [24:0]       lfsr_q;

    logic [2:0]        cmd_q;
    logic              fetching_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [15:0]       err_q;
    logic [15:0]       rsp_q;

    logic              can_issue;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] seq_d;
    logic [24:0]       lfsr_d;
    logic              rsp_window;
    logic              rsp_bad;
    logic [15:0]       err_d;
    logic [15:0]       rsp_d;
    logic              finish_d;

    // Issue gating, address generator step and response checking.
    always_comb begin
        can_issue  = notfull_i && (int'(fillcount_i) < FILL_LIMIT);
        gen_addr   = (ADDR_MODE != 0) ? ADDR_W'(lfsr_q) : seq_q;
        wr_data    = DATA_W'(gen_addr) ^ DATA_XOR;
        seq_d      = seq_q + ADDR_W'(STRIDE);
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        rsp_window = (state_q == S_RD) || (state_q == S_WAIT_RSP);
        // A response is checked by its own raddr, so arrival order is irrelevant.
        rsp_bad    = validout_i &&
                     (!rsp_window || (dout_i != (DATA_W'(raddr_i) ^ DATA_XOR)));
        err_d      = err_q;
        if (rsp_bad && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
        rsp_d      = rsp_q;
        if (validout_i && rsp_window && (rsp_q != 16'hFFFF)) begin
            rsp_d = rsp_q + 16'd1;
        end
        // Leave WAIT_RSP when every read is answered or the idle timer expires.
        finish_d   = (rsp_d >= RSP_GOAL) || (!validout_i && (tmr_q <= TMR_W'(1)));
    end

    // Run sequencer with all host-port and status outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            tmr_q      <= '0;
            seq_q      <= '0;
            lfsr_q     <= '0;
            cmd_q      <= CMD_NOP;
            fetching_q <= 1'b0;
            din_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            rsp_q      <= '0;
        end else begin
            fetching_q <= 1'b0;
            cmd_q      <= CMD_NOP;
            err_q      <= err_d;
            rsp_q      <= rsp_d;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q  <= S_WAIT_RDY;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        err_q    <= '0;
                        rsp_q    <= '0;
                        remain_q <= CNT_LOAD;
                        seq_q    <= BASE_ADDR;
                        lfsr_q   <= SEED_EFF;
                    end
                end

                S_WAIT_RDY: begin
                    if (ready_i) begin
                        state_q <= S_WR;
                    end
                end

                S_WR: begin
                    if (can_issue) begin
                        fetching_q <= 1'b1;
                        cmd_q      <= CMD_SCW;
                        addr_q     <= gen_addr;
                        din_q      <= wr_data;
                        seq_q      <= seq_d;
                        lfsr_q     <= lfsr_d;
                        remain_q   <= remain_q - CNT_W'(1);
                        // Rewind the generator so reads replay the write addresses.
                        if (remain_q == CNT_W'(1)) begin
                            state_q  <= S_RD;
                            remain_q <= CNT_LOAD;
                            seq_q    <= BASE_ADDR;
                            lfsr_q   <= SEED_EFF;
                        end
                    end
                end

                S_RD: begin
                    if (can_issue) begin
                        fetching_q <= 1'b1;
                        cmd_q      <= CMD_SCR;
                        addr_q     <= gen_addr;
                        din_q      <= '0;
                        seq_q      <= seq_d;
                        lfsr_q     <= lfsr_d;
                        remain_q   <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= S_WAIT_RSP;
                            tmr_q   <= TMR_LOAD;
                        end
                    end
                end

                S_WAIT_RSP: begin
                    if (finish_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 16'd0) && (rsp_d == RSP_GOAL);
                    end else if (validout_i) begin
                        tmr_q <= TMR_LOAD;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_o       = cmd_q;
    assign sz_o        = 2'd0;
    assign op_o        = 3'd0;
    assign fetching_o  = fetching_q;
    assign din_o       = din_q;
    assign addr_o      = addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign rsp_count_o = rsp_q;

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Bench for ddr2_traffic_gen. DUT A is a sequential-address engine with four
// transactions, driven by a vector table and directed runs. DUT B is an LFSR
// engine with eight transactions, driven by random issue gating and random
// response corruption and checked against a scoreboard of written words.
module tb_ddr2_traffic_gen;

    localparam int          N_A = 4;
    localparam int          N_B = 8;
    localparam int          TO  = 4096;
    localparam logic [15:0] XOR = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic        ready, notfull, validout;
    logic [6:0]  fillcount;
    logic [15:0] dout;
    logic [24:0] raddr;

    logic [2:0]  cmd_a, op_a, cmd_b, op_b;
    logic [1:0]  sz_a, sz_b;
    logic        fetching_a, busy_a, done_a, pass_a;
    logic        fetching_b, busy_b, done_b, pass_b;
    logic [15:0] din_a, din_b, err_a, err_b, rsp_a, rsp_b;
    logic [24:0] addr_a, addr_b;

    ddr2_traffic_gen #(.NUM_TXN(N_A), .ADDR_MODE(0), .TIMEOUT_CYC(TO)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .ready_i(ready),
        .fillcount_i(fillcount), .notfull_i(notfull), .dout_i(dout),
        .raddr_i(raddr), .validout_i(validout), .cmd_o(cmd_a), .sz_o(sz_a),
        .op_o(op_a), .fetching_o(fetching_a), .din_o(din_a), .addr_o(addr_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_count_o(err_a), .rsp_count_o(rsp_a));

    ddr2_traffic_gen #(.NUM_TXN(N_B), .ADDR_MODE(1), .TIMEOUT_CYC(TO)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .start_i(start_b), .ready_i(ready),
        .fillcount_i(fillcount), .notfull_i(notfull), .dout_i(dout),
        .raddr_i(raddr), .validout_i(validout), .cmd_o(cmd_b), .sz_o(sz_b),
        .op_o(op_b), .fetching_o(fetching_b), .din_o(din_b), .addr_o(addr_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_count_o(err_b), .rsp_count_o(rsp_b));

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         nf;
        logic [6:0] fc;
        int         reps;
        bit         exp_fetch;
    } vec_t;

    vec_t        tbl [9];
    logic [24:0] wq[$];
    logic [24:0] rq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rsp(input logic [24:0] a, input logic [15:0] d);
        raddr    = a;
        dout     = d;
        validout = 1'b1;
        tick();
        validout = 1'b0;
    endtask

    // Counts cycles until done on the selected DUT; an expired bound is a failure.
    task automatic wait_done(input bit use_b, input int bound, output int cyc);
        cyc = 0;
        while (!(use_b ? done_b : done_a) && cyc < bound) begin
            tick();
            cyc++;
        end
        if (!(use_b ? done_b : done_a)) begin
            total++;
            bad++;
            $display("FAIL wait_done: no done within %0d cycles", bound);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Runs DUT A with no issue gating until it has issued 2*N_A commands.
    task automatic issue_all_a();
        int k;
        int guard;
        k = 0;
        guard = 0;
        notfull = 1'b1;
        fillcount = 7'd0;
        pulse_start_a();
        while (k < 2 * N_A && guard < 100) begin
            tick();
            guard++;
            if (fetching_a) k++;
        end
        chk("a_issue_count", k, 2 * N_A);
    endtask

    // Random gating on DUT B; every cycle the issue outcome is compared with the
    // rule "issue iff notfull and fillcount<56 while commands remain".
    task automatic drive_b(input int stop_reads);
        int  guard;
        bit  ok;
        guard = 0;
        while ((wq.size() + rq.size()) < 2 * N_B && int'(rq.size()) < stop_reads
               && guard < 2000) begin
            notfull   = ($urandom_range(0, 3) != 0);
            fillcount = 7'($urandom_range(50, 60));
            if ($urandom_range(0, 2) == 0) fillcount = 7'd0;
            ok = notfull && (fillcount < 7'd56);
            tick();
            guard++;
            chk("b_fetch_rule", fetching_b, ok);
            if (fetching_b) begin
                if (wq.size() < N_B) begin
                    chk("b_wr_cmd", cmd_b, 3'd2);
                    chk("b_wr_din", din_b, addr_b[15:0] ^ XOR);
                    wq.push_back(addr_b);
                end else begin
                    chk("b_rd_cmd", cmd_b, 3'd1);
                    chk("b_rd_din", din_b, 16'd0);
                    rq.push_back(addr_b);
                end
            end
        end
        notfull   = 1'b0;
        fillcount = 7'd0;
    endtask

    initial begin
        int          k;
        int          cyc;
        int          n_corrupt;
        logic [24:0] exp_addr;
        logic [24:0] order[$];
        logic [24:0] tmp;
        logic [15:0] d;

        tbl[0] = '{1'b1, 7'd0,   1,  1'b1};
        tbl[1] = '{1'b0, 7'd0,   10, 1'b0};
        tbl[2] = '{1'b1, 7'd0,   1,  1'b1};
        tbl[3] = '{1'b1, 7'd56,  3,  1'b0};
        tbl[4] = '{1'b1, 7'd55,  1,  1'b1};
        tbl[5] = '{1'b1, 7'd0,   1,  1'b1};
        tbl[6] = '{1'b1, 7'd127, 2,  1'b0};
        tbl[7] = '{1'b1, 7'd0,   4,  1'b1};
        tbl[8] = '{1'b0, 7'd0,   3,  1'b0};

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ready = 1'b1; notfull = 1'b0; validout = 1'b0;
        fillcount = 7'd0; dout = '0; raddr = '0;
        repeat (3) tick();

        chk("a_reset_outs", |{cmd_a, sz_a, op_a, fetching_a, din_a, addr_a,
                              busy_a, done_a, pass_a, err_a, rsp_a}, 1'b0);
        rst_a = 1'b0;
        tick();
        chk("a_idle_busy", busy_a, 1'b0);

        // Test 1-3: table-driven issue gating over one whole run.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_busy_after_start", busy_a, 1'b1);
        tick();
        k = 0;
        foreach (tbl[r]) begin
            for (int rep = 0; rep < tbl[r].reps; rep++) begin
                notfull   = tbl[r].nf;
                fillcount = tbl[r].fc;
                tick();
                chk("a_fetch_row", fetching_a, tbl[r].exp_fetch);
                if (fetching_a) begin
                    exp_addr = 25'((k % N_A) * 8);
                    chk("a_cmd", cmd_a, (k < N_A) ? 3'd2 : 3'd1);
                    chk("a_addr", addr_a, exp_addr);
                    chk("a_din", din_a, (k < N_A) ? (exp_addr[15:0] ^ XOR) : 16'd0);
                    k++;
                end
            end
        end
        chk("a_table_issues", k, 2 * N_A);
        chk("a_sz_op", {sz_a, op_a}, 5'd0);
        chk("a_busy_wait_rsp", busy_a, 1'b1);

        // Responses out of order are still matched by raddr.
        send_rsp(25'd24, 16'd24 ^ XOR);
        send_rsp(25'd0,  16'd0  ^ XOR);
        send_rsp(25'd16, 16'd16 ^ XOR);
        chk("a_no_early_done", done_a, 1'b0);
        send_rsp(25'd8,  16'd8  ^ XOR);
        wait_done(1'b0, 20, cyc);
        chk("a1_done", done_a, 1'b1);
        chk("a1_pass", pass_a, 1'b1);
        chk("a1_err", err_a, 16'd0);
        chk("a1_rsp", rsp_a, 16'd4);
        chk("a1_busy", busy_a, 1'b0);
        repeat (5) tick();
        chk("a1_done_held", done_a, 1'b1);

        // Test 4: one response with bit 0 flipped.
        issue_all_a();
        send_rsp(25'd0,  16'd0  ^ XOR);
        send_rsp(25'd8,  (16'd8 ^ XOR) ^ 16'd1);
        send_rsp(25'd16, 16'd16 ^ XOR);
        send_rsp(25'd24, 16'd24 ^ XOR);
        wait_done(1'b0, 20, cyc);
        chk("a4_err", err_a, 16'd1);
        chk("a4_pass", pass_a, 1'b0);
        chk("a4_rsp", rsp_a, 16'd4);

        // Test 5: only three responses, run ends on the idle timeout.
        issue_all_a();
        chk("a5_counters_cleared", {err_a, rsp_a}, 32'd0);
        send_rsp(25'd0,  16'd0  ^ XOR);
        send_rsp(25'd8,  16'd8  ^ XOR);
        send_rsp(25'd16, 16'd16 ^ XOR);
        wait_done(1'b0, TO + 50, cyc);
        chk("a5_timeout_window", (cyc >= TO - 2) && (cyc <= TO + 2), 1'b1);
        chk("a5_not_early", cyc > 100, 1'b1);
        chk("a5_pass", pass_a, 1'b0);
        chk("a5_rsp", rsp_a, 16'd3);
        chk("a5_err", err_a, 16'd0);
        send_rsp(25'd24, 16'd24 ^ XOR);
        chk("a5_unexpected_err", err_a, 16'd1);
        chk("a5_unexpected_rsp", rsp_a, 16'd3);

        // Test 6: DUT B reset during RD, then clean random LFSR runs.
        rst_a = 1'b1;
        rst_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        wq.delete();
        rq.delete();
        drive_b(3);
        chk("b_reached_rd", rq.size() >= 3, 1'b1);
        rst_b = 1'b1;
        tick();
        chk("b_reset_outs", |{cmd_b, sz_b, op_b, fetching_b, din_b, addr_b,
                              busy_b, done_b, pass_b, err_b, rsp_b}, 1'b0);
        rst_b = 1'b0;
        repeat (3) tick();
        chk("b_stays_idle", busy_b | fetching_b | done_b, 1'b0);

        for (int run = 0; run < 3; run++) begin
            wq.delete();
            rq.delete();
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            tick();
            drive_b(N_B);
            chk("b_write_count", wq.size(), N_B);
            chk("b_read_count", rq.size(), N_B);
            chk("b_first_addr_seed", wq[0], 25'h1ACE1);
            for (int i = 0; i < N_B && i < int'(rq.size()) && i < int'(wq.size()); i++)
                chk("b_read_replays_write", rq[i], wq[i]);

            order = wq;
            for (int i = N_B - 1; i > 0; i--) begin
                int j;
                j = $urandom_range(0, i);
                tmp = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            n_corrupt = 0;
            foreach (order[i]) begin
                d = order[i][15:0] ^ XOR;
                if (run > 0 && $urandom_range(0, 2) == 0) begin
                    d = d ^ 16'($urandom_range(1, 16'hFFFF));
                    n_corrupt++;
                end
                send_rsp(order[i], d);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_done(1'b1, 50, cyc);
            chk("b_err", err_b, 16'(n_corrupt));
            chk("b_rsp", rsp_b, 16'(N_B));
            chk("b_pass", pass_b, n_corrupt == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
